// File: rtl/router_fsm_nch.sv
// Control FSM for a 1xN packet router: decodes the header address, steers the packet to one
// output FIFO, and sequences the payload, full-stall, parity, drop and wait-till-empty phases.
module router_fsm_nch #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    output logic [NUM_CH-1:0] dest_sel,
    output logic              detect_addr,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              drop_state,
    output logic              write_enb_reg,
    output logic              busy,
    output logic              timeout
);
    localparam int unsigned WCNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        WAIT_TILL_EMPTY,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        CHECK_PARITY_ERROR,
        DROP_PKT
    } state_e;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] dest_sel_q, dest_sel_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic              detect_addr_q, detect_addr_d;
    logic              lfd_state_q, lfd_state_d;
    logic              ld_state_q, ld_state_d;
    logic              laf_state_q, laf_state_d;
    logic              full_state_q, full_state_d;
    logic              rst_int_reg_q, rst_int_reg_d;
    logic              drop_state_q, drop_state_d;
    logic              write_enb_reg_q, write_enb_reg_d;
    logic              busy_q, busy_d;

    logic              addr_ok;
    logic [NUM_CH-1:0] addr_oh;
    logic              dest_empty;
    logic              soft_hit;

    // Header address qualification against the channel count, and per-destination qualifiers.
    always_comb begin
        addr_ok    = 32'(data_in) < NUM_CH;
        addr_oh    = addr_ok ? (NUM_CH'(1) << data_in) : '0;
        dest_empty = |(fifo_empty & dest_sel_q);
        soft_hit   = |(soft_reset & dest_sel_q);
    end

    // Next-state, destination latch, wait counter and registered output decodes.
    always_comb begin
        state_d    = state_q;
        dest_sel_d = dest_sel_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!addr_ok) begin
                        state_d = DROP_PKT;
                    end else begin
                        dest_sel_d = addr_oh;
                        wait_cnt_d = '0;
                        state_d    = |(fifo_empty & addr_oh) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                if (dest_empty) begin
                    state_d    = LOAD_FIRST_DATA;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_W'(WAIT_MAX - 1)) begin
                    state_d    = DROP_PKT;
                    timeout_d  = 1'b1;
                    dest_sel_d = '0;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            DROP_PKT: begin
                if (!pkt_valid) state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // A soft reset only matters for the channel this packet is bound to.
        if (soft_hit) begin
            state_d   = DECODE_ADDRESS;
            timeout_d = 1'b0;
        end

        // dest_sel is zero whenever the FSM is idle.
        if (state_d == DECODE_ADDRESS) begin
            dest_sel_d = '0;
            wait_cnt_d = '0;
        end

        detect_addr_d   = state_d == DECODE_ADDRESS;
        lfd_state_d     = state_d == LOAD_FIRST_DATA;
        ld_state_d      = state_d == LOAD_DATA;
        laf_state_d     = state_d == LOAD_AFTER_FULL;
        full_state_d    = state_d == FIFO_FULL_STATE;
        rst_int_reg_d   = state_d == CHECK_PARITY_ERROR;
        drop_state_d    = state_d == DROP_PKT;
        write_enb_reg_d = (state_d == LOAD_DATA) || (state_d == LOAD_PARITY)
                          || (state_d == LOAD_AFTER_FULL);
        busy_d          = (state_d == LOAD_FIRST_DATA) || (state_d == WAIT_TILL_EMPTY)
                          || (state_d == FIFO_FULL_STATE) || (state_d == LOAD_AFTER_FULL)
                          || (state_d == LOAD_PARITY) || (state_d == CHECK_PARITY_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= DECODE_ADDRESS;
            dest_sel_q      <= '0;
            wait_cnt_q      <= '0;
            timeout_q       <= 1'b0;
            detect_addr_q   <= 1'b1;
            lfd_state_q     <= 1'b0;
            ld_state_q      <= 1'b0;
            laf_state_q     <= 1'b0;
            full_state_q    <= 1'b0;
            rst_int_reg_q   <= 1'b0;
            drop_state_q    <= 1'b0;
            write_enb_reg_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            dest_sel_q      <= dest_sel_d;
            wait_cnt_q      <= wait_cnt_d;
            timeout_q       <= timeout_d;
            detect_addr_q   <= detect_addr_d;
            lfd_state_q     <= lfd_state_d;
            ld_state_q      <= ld_state_d;
            laf_state_q     <= laf_state_d;
            full_state_q    <= full_state_d;
            rst_int_reg_q   <= rst_int_reg_d;
            drop_state_q    <= drop_state_d;
            write_enb_reg_q <= write_enb_reg_d;
            busy_q          <= busy_d;
        end
    end

    assign dest_sel      = dest_sel_q;
    assign detect_addr   = detect_addr_q;
    assign lfd_state     = lfd_state_q;
    assign ld_state      = ld_state_q;
    assign laf_state     = laf_state_q;
    assign full_state    = full_state_q;
    assign rst_int_reg   = rst_int_reg_q;
    assign drop_state    = drop_state_q;
    assign write_enb_reg = write_enb_reg_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Bench for router_fsm_nch: phase-level behavioural model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_router_fsm_nch;
    localparam int unsigned NUM_CH   = 3;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned WAIT_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;
    logic [NUM_CH-1:0] dest_sel;
    logic detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg, drop_state;
    logic write_enb_reg, busy, timeout;

    always #5 clk = ~clk;

    router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .soft_reset(soft_reset), .dest_sel(dest_sel),
        .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .drop_state(drop_state), .write_enb_reg(write_enb_reg), .busy(busy), .timeout(timeout)
    );

    // Model phases (the packet's current activity).
    localparam int P_DEC = 0, P_LFD = 1, P_WTE = 2, P_LD = 3, P_LP = 4;
    localparam int P_FULL = 5, P_LAF = 6, P_CPE = 7, P_DROP = 8;

    int m_ph    = P_DEC;
    int m_dest  = -1;
    int m_waits = 0;
    bit m_to    = 1'b0;
    int n_pass  = 0;
    int n_total = 0;
    bit checking = 1'b0;

    always @(posedge clk) begin : model
        m_to = 1'b0;
        if (reset) begin
            m_ph = P_DEC; m_dest = -1; m_waits = 0;
        end else if (m_dest >= 0 && soft_reset[m_dest]) begin
            m_ph = P_DEC; m_dest = -1; m_waits = 0;
        end else begin
            case (m_ph)
                P_DEC: if (pkt_valid) begin
                    if (int'(data_in) >= int'(NUM_CH)) m_ph = P_DROP;
                    else begin
                        m_dest  = int'(data_in);
                        m_waits = 0;
                        m_ph    = fifo_empty[data_in] ? P_LFD : P_WTE;
                    end
                end
                P_WTE: begin
                    m_waits++;
                    if (fifo_empty[m_dest]) m_ph = P_LFD;
                    else if (m_waits == int'(WAIT_MAX)) begin
                        m_ph = P_DROP; m_to = 1'b1; m_dest = -1;
                    end
                end
                P_LFD:  m_ph = P_LD;
                P_LD:   if (fifo_full) m_ph = P_FULL; else if (!pkt_valid) m_ph = P_LP;
                P_FULL: if (!fifo_full) m_ph = P_LAF;
                P_LAF:  m_ph = parity_done ? P_DEC : (low_pkt_valid ? P_LP : P_LD);
                P_LP:   m_ph = P_CPE;
                P_CPE:  m_ph = fifo_full ? P_FULL : P_DEC;
                P_DROP: if (!pkt_valid) m_ph = P_DEC;
                default: m_ph = P_DEC;
            endcase
            if (m_ph == P_DEC) m_dest = -1;
        end
    end

    function automatic logic [12:0] exp_vec();
        logic [2:0] ds;
        logic we, bz;
        ds = (m_dest < 0) ? 3'b000 : 3'(1 << m_dest);
        we = (m_ph == P_LD) || (m_ph == P_LP) || (m_ph == P_LAF);
        bz = (m_ph == P_LFD) || (m_ph == P_WTE) || (m_ph == P_FULL) || (m_ph == P_LAF)
             || (m_ph == P_LP) || (m_ph == P_CPE);
        return {ds, m_ph == P_DEC, m_ph == P_LFD, m_ph == P_LD, m_ph == P_LAF,
                m_ph == P_FULL, m_ph == P_CPE, m_ph == P_DROP, we, bz, m_to};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {dest_sel, detect_addr, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, drop_state, write_enb_reg, busy, timeout};
    endfunction

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin : compare
        if (checking) chk("cycle", dut_vec(), exp_vec());
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = '0; parity_done = 1'b0;
        low_pkt_valid = 1'b0; fifo_full = 1'b0; fifo_empty = 3'b111; soft_reset = '0;
        tick();
        checking = 1'b1;
        tick();
        chk("reset_vals", dut_vec(), 13'b000_1000_0000_00);
        reset = 1'b0;

        // Empty destination: header -> first data -> payload -> parity -> check -> idle.
        pkt_valid = 1'b1; data_in = 2'd1;
        tick();
        chk("lfd_dest", 13'(dest_sel), 13'(3'b010));
        chk("lfd_flag", 13'({lfd_state, busy, write_enb_reg}), 13'(3'b110));
        tick();
        chk("ld_we", 13'({ld_state, write_enb_reg}), 13'(2'b11));
        tick();
        pkt_valid = 1'b0;
        tick();
        tick();
        chk("cpe", 13'({rst_int_reg, busy}), 13'(2'b11));
        tick();
        chk("idle_after_pkt", 13'({dest_sel, detect_addr}), 13'(4'b0001));

        // Busy destination: only the latched channel's empty flag matters.
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
        tick();
        chk("wte_busy", 13'({busy, write_enb_reg, dest_sel}), 13'(5'b10100));
        fifo_empty = 3'b010;
        tick();
        chk("wte_other_ch", 13'({busy, lfd_state}), 13'(2'b10));
        fifo_empty = 3'b111;
        tick();
        chk("wte_to_lfd", 13'(lfd_state), 13'(1'b1));
        tick();
        pkt_valid = 1'b0;
        tick(); tick(); tick();

        // Invalid address: packet dropped, no writes, no busy.
        pkt_valid = 1'b1; data_in = 2'd3;
        tick();
        chk("drop_enter", 13'({drop_state, busy, write_enb_reg, dest_sel}), 13'(6'b100000));
        tick(); tick(); tick();
        chk("drop_hold", 13'(drop_state), 13'(1'b1));
        pkt_valid = 1'b0;
        tick();
        chk("drop_exit", 13'(detect_addr), 13'(1'b1));

        // Destination never empties: WAIT_MAX cycles waiting, then a timeout drop.
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b110;
        tick(); tick(); tick(); tick();
        chk("wte_4th", 13'({busy, timeout, drop_state}), 13'(3'b100));
        tick();
        chk("timeout_pulse", 13'({timeout, drop_state, dest_sel}), 13'(5'b11000));
        tick();
        chk("timeout_once", 13'({timeout, drop_state}), 13'(2'b01));
        pkt_valid = 1'b0; fifo_empty = 3'b111;
        tick();

        // Full stall, then low_pkt_valid out of LOAD_AFTER_FULL.
        pkt_valid = 1'b1; data_in = 2'd0;
        tick(); tick();
        fifo_full = 1'b1;
        tick(); tick(); tick();
        chk("full_3rd", 13'({full_state, busy, write_enb_reg}), 13'(3'b110));
        fifo_full = 1'b0;
        tick();
        chk("laf", 13'({laf_state, write_enb_reg}), 13'(2'b11));
        low_pkt_valid = 1'b1;
        tick();
        chk("laf_to_lp", 13'({write_enb_reg, ld_state, busy}), 13'(3'b101));
        low_pkt_valid = 1'b0; pkt_valid = 1'b0;
        tick(); tick();

        // Full stall, then parity_done straight back to idle.
        pkt_valid = 1'b1;
        tick(); tick();
        fifo_full = 1'b1;
        tick();
        fifo_full = 1'b0;
        tick();
        parity_done = 1'b1; pkt_valid = 1'b0;
        tick();
        chk("laf_parity_done", 13'({detect_addr, dest_sel}), 13'(4'b1000));
        parity_done = 1'b0;

        // Soft reset: only the bound channel counts; reset still wins.
        pkt_valid = 1'b1; data_in = 2'd0;
        tick(); tick();
        soft_reset = 3'b100;
        tick();
        chk("soft_other", 13'({ld_state, dest_sel}), 13'(4'b1001));
        soft_reset = 3'b001;
        tick();
        chk("soft_hit", 13'({detect_addr, dest_sel}), 13'(4'b1000));
        soft_reset = 3'b000;
        tick(); tick();
        reset = 1'b1; soft_reset = 3'b001;
        tick();
        chk("reset_and_soft", dut_vec(), 13'b000_1000_0000_00);
        reset = 1'b0; soft_reset = 3'b000; pkt_valid = 1'b0;
        tick(); tick();

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
